// File: rtl/rv32_fetch_seq_if.sv
// Fetch/execute port bundle for rv32_fetch_seq.
//   master : the sequencer. Drives the instruction-memory request, the held
//            instruction towards execute and the trap/retire status.
//   slave  : the environment (instruction memory, execute and branch unit,
//            CSR file). Returns fetch data, retire/redirect and the trap vector.
// Signals:
//   imem_req/imem_addr      fetch request and address (address = pc)
//   imem_ack/rdata/err      fetch completion, data and access fault
//   instr_valid/instr/pc    held instruction presented to execute
//   exec_done               execute retires the held instruction
//   branch_taken/target     redirect, sampled with exec_done
//   trap_vec                trap handler base (mtvec)
//   trap/trap_cause/trap_pc one-cycle trap pulse and its sticky details
//   instret                 retired-instruction counter
interface rv32_fetch_seq_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        exec_done;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] trap_vec;
    logic        trap;
    logic [3:0]  trap_cause;
    logic [31:0] trap_pc;
    logic [63:0] instret;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata, imem_err,
        output instr_valid, instr, instr_pc,
        input  exec_done, branch_taken, branch_target, trap_vec,
        output trap, trap_cause, trap_pc, instret
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata, imem_err,
        input  instr_valid, instr, instr_pc,
        output exec_done, branch_taken, branch_target, trap_vec,
        input  trap, trap_cause, trap_pc, instret
    );
endinterface

// File: rtl/rv32_fetch_seq.sv
// Instruction-sequencing controller for the rv32imc single-stage core.
// Owns the PC, fetches one instruction at a time over a req/ack port, holds it
// for execute, advances the PC on retire (+2 for RVC, +4 otherwise) or applies
// the branch redirect, and turns fetch faults, misaligned targets and illegal
// compressed encodings into a one-cycle trap pulse followed by a jump to mtvec.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rv32_fetch_seq_if.master (memory, execute and trap signals)
// Parameters:
//   RESET_PC   PC loaded on reset
//   SUPPORT_C  1: RVC legal, halfword-aligned PCs; 0: RVC illegal, word-aligned
module rv32_fetch_seq #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter bit          SUPPORT_C = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    rv32_fetch_seq_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, TRAP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic [3:0]  trap_cause_q, trap_cause_d;
    logic [31:0] trap_pc_q, trap_pc_d;
    logic [63:0] instret_q;
    logic        load_instr;
    logic        retire;
    logic [31:0] step;
    logic [31:0] br_tgt;
    logic        unused_bits;

    // Bits the sequencer never looks at: mtvec mode bits and bit 0 of the
    // redirect (always cleared to halfword alignment).
    assign unused_bits = ^{bus.trap_vec[1:0], bus.branch_target[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        trap_cause_d = trap_cause_q;
        trap_pc_d    = trap_pc_q;
        load_instr   = 1'b0;
        retire       = 1'b0;
        step         = (instr_q[1:0] != 2'b11) ? 32'd2 : 32'd4;
        br_tgt       = {bus.branch_target[31:1], 1'b0};
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (bus.imem_ack) begin
                    if (bus.imem_err) begin
                        state_d      = TRAP;
                        trap_cause_d = 4'd1;
                        trap_pc_d    = pc_q;
                    end else if (!SUPPORT_C && (bus.imem_rdata[1:0] != 2'b11)) begin
                        // Compressed encoding on a core built without RVC.
                        state_d      = TRAP;
                        trap_cause_d = 4'd2;
                        trap_pc_d    = pc_q;
                    end else begin
                        state_d    = EXEC;
                        load_instr = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (bus.exec_done) begin
                    retire = 1'b1;
                    // Without RVC a taken branch must land on a word boundary;
                    // the instruction still retires, the PC is left alone.
                    if (!SUPPORT_C && bus.branch_taken && bus.branch_target[1]) begin
                        state_d      = TRAP;
                        trap_cause_d = 4'd0;
                        trap_pc_d    = bus.branch_target;
                    end else begin
                        state_d = FETCH;
                        pc_d    = bus.branch_taken ? br_tgt : pc_q + step;
                    end
                end
            end
            TRAP: begin
                state_d = FETCH;
                pc_d    = {bus.trap_vec[31:2], 2'b00};
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            instr_q      <= 32'd0;
            instr_pc_q   <= RESET_PC;
            trap_cause_q <= 4'd0;
            trap_pc_q    <= 32'd0;
            instret_q    <= 64'd0;
        end else begin
            pc_q         <= pc_d;
            trap_cause_q <= trap_cause_d;
            trap_pc_q    <= trap_pc_d;
            if (load_instr) begin
                instr_q    <= bus.imem_rdata;
                instr_pc_q <= pc_q;
            end
            if (retire) begin
                instret_q <= instret_q + 64'd1;
            end
        end
    end

    // Request and valid decode straight from state, so an asserted reset
    // drops imem_req in the same cycle and the two can never overlap.
    assign bus.imem_req    = (state_q == FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (state_q == EXEC);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.trap        = (state_q == TRAP);
    assign bus.trap_cause  = trap_cause_q;
    assign bus.trap_pc     = trap_pc_q;
    assign bus.instret     = instret_q;
endmodule

// File: tb/tb_rv32_fetch_seq.sv
// Directed bench for rv32_fetch_seq. Two instances: dut_c (SUPPORT_C=1) and
// dut_w (SUPPORT_C=0) share the stimulus; the one not under test is held in reset.
module tb_rv32_fetch_seq;
    logic clk;
    logic rst_c_n, rst_w_n;
    logic sel;
    logic ack, err, done, taken;
    logic [31:0] rdata, tgt, tvec;
    int total, bad;

    logic        o_req, o_valid, o_trap;
    logic [31:0] o_addr, o_instr, o_ipc, o_tpc;
    logic [3:0]  o_cause;
    logic [63:0] o_instret;

    rv32_fetch_seq_if ifc();
    rv32_fetch_seq_if ifw();

    rv32_fetch_seq #(.RESET_PC(32'h0000_0000), .SUPPORT_C(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_c_n), .bus(ifc.master));
    rv32_fetch_seq #(.RESET_PC(32'h0000_0000), .SUPPORT_C(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_w_n), .bus(ifw.master));

    assign ifc.imem_ack = ack;   assign ifw.imem_ack = ack;
    assign ifc.imem_rdata = rdata; assign ifw.imem_rdata = rdata;
    assign ifc.imem_err = err;   assign ifw.imem_err = err;
    assign ifc.exec_done = done; assign ifw.exec_done = done;
    assign ifc.branch_taken = taken; assign ifw.branch_taken = taken;
    assign ifc.branch_target = tgt;  assign ifw.branch_target = tgt;
    assign ifc.trap_vec = tvec;  assign ifw.trap_vec = tvec;

    always_comb begin
        if (sel) begin
            o_req = ifw.imem_req;   o_addr = ifw.imem_addr; o_valid = ifw.instr_valid;
            o_instr = ifw.instr;    o_ipc = ifw.instr_pc;   o_trap = ifw.trap;
            o_cause = ifw.trap_cause; o_tpc = ifw.trap_pc;  o_instret = ifw.instret;
        end else begin
            o_req = ifc.imem_req;   o_addr = ifc.imem_addr; o_valid = ifc.instr_valid;
            o_instr = ifc.instr;    o_ipc = ifc.instr_pc;   o_trap = ifc.trap;
            o_cause = ifc.trap_cause; o_tpc = ifc.trap_pc;  o_instret = ifc.instret;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; sel = 1'b0;
        rst_c_n = 1'b0; rst_w_n = 1'b0;
        ack = 0; err = 0; done = 0; taken = 0;
        rdata = 32'd0; tgt = 32'd0; tvec = 32'h0000_0203;
        #1;
        // Reset values
        chk("rst_req", o_req, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_addr", o_addr, 32'h0);
        chk("rst_instr", o_instr, 32'h0);
        chk("rst_ipc", o_ipc, 32'h0);
        chk("rst_trap", o_trap, 0);
        chk("rst_cause", o_cause, 0);
        chk("rst_tpc", o_tpc, 32'h0);
        chk("rst_instret", o_instret, 64'h0);

        // Reset release: one IDLE cycle, then FETCH at RESET_PC
        step(); rst_c_n = 1'b1;
        chk("idle_req", o_req, 0);
        step();
        chk("fetch_req", o_req, 1);
        chk("fetch_addr", o_addr, 32'h0);

        // Reset mid-fetch drops req immediately; stale ack ignored
        rst_c_n = 1'b0; #1;
        chk("midrst_req", o_req, 0);
        ack = 1; rdata = 32'h0000_0013;
        step(); rst_c_n = 1'b1;
        chk("rel_req", o_req, 0);
        chk("rel_valid", o_valid, 0);
        step(); ack = 0;
        chk("stale_valid", o_valid, 0);
        chk("stale_req", o_req, 1);
        chk("stale_addr", o_addr, 32'h0);

        // Sequential: 32-bit at 0, then c.nop at 4
        ack = 1; rdata = 32'h0000_0013;
        step(); ack = 0;
        chk("seq1_valid", o_valid, 1);
        chk("seq1_req", o_req, 0);
        chk("seq1_instr", o_instr, 32'h0000_0013);
        chk("seq1_ipc", o_ipc, 32'h0);
        done = 1;
        step(); done = 0;
        chk("seq1_next", o_addr, 32'h4);
        chk("seq1_req2", o_req, 1);
        chk("seq1_ret", o_instret, 64'd1);
        ack = 1; rdata = 32'h0000_0001;
        step(); ack = 0;
        chk("seq2_ipc", o_ipc, 32'h4);
        done = 1;
        step(); done = 0;
        chk("seq2_next", o_addr, 32'h6);
        chk("seq2_ret", o_instret, 64'd2);

        // Redirect: branch_taken without exec_done ignored, then taken to 0x101
        ack = 1; rdata = 32'h0000_0013;
        step(); ack = 0;
        taken = 1; tgt = 32'h0000_0101;
        step();
        chk("nodone_valid", o_valid, 1);
        chk("nodone_ipc", o_ipc, 32'h6);
        chk("nodone_addr", o_addr, 32'h6);
        done = 1;
        step(); done = 0; taken = 0;
        chk("redir_addr", o_addr, 32'h100);
        chk("redir_ret", o_instret, 64'd3);

        // Wrap: branch to FFFF_FFFC, retire 32-bit there -> 0
        ack = 1; rdata = 32'h0000_0013;
        step(); ack = 0;
        done = 1; taken = 1; tgt = 32'hFFFF_FFFC;
        step(); done = 0; taken = 0;
        chk("wrap_pre", o_addr, 32'hFFFF_FFFC);
        ack = 1;
        step(); ack = 0;
        chk("wrap_ipc", o_ipc, 32'hFFFF_FFFC);
        done = 1;
        step(); done = 0;
        chk("wrap_addr", o_addr, 32'h0);
        chk("wrap_ret", o_instret, 64'd5);

        // Fetch access fault at pc 8
        ack = 1;
        step(); ack = 0;
        done = 1; taken = 1; tgt = 32'h8;
        step(); done = 0; taken = 0;
        chk("flt_addr", o_addr, 32'h8);
        ack = 1; err = 1;
        step(); ack = 0; err = 0;
        chk("flt_trap", o_trap, 1);
        chk("flt_cause", o_cause, 4'd1);
        chk("flt_tpc", o_tpc, 32'h8);
        chk("flt_valid", o_valid, 0);
        chk("flt_req", o_req, 0);
        step();
        chk("flt_trap_end", o_trap, 0);
        chk("flt_vec", o_addr, 32'h200);
        chk("flt_hold_cause", o_cause, 4'd1);
        chk("flt_hold_tpc", o_tpc, 32'h8);
        chk("flt_ret", o_instret, 64'd6);

        // Switch to the word-aligned instance
        rst_c_n = 1'b0; sel = 1'b1; rst_w_n = 1'b1;
        step();
        chk("w_req", o_req, 1);
        chk("w_addr", o_addr, 32'h0);

        // Illegal RVC on SUPPORT_C=0
        ack = 1; rdata = 32'h0000_4501;
        step(); ack = 0;
        chk("ill_trap", o_trap, 1);
        chk("ill_cause", o_cause, 4'd2);
        chk("ill_tpc", o_tpc, 32'h0);
        chk("ill_valid", o_valid, 0);
        chk("ill_ret", o_instret, 64'd0);
        step();
        chk("ill_trap_end", o_trap, 0);
        chk("ill_valid2", o_valid, 0);
        chk("ill_vec", o_addr, 32'h200);

        // Misaligned taken target on SUPPORT_C=0
        ack = 1; rdata = 32'h0000_0013;
        step(); ack = 0;
        chk("mis_valid", o_valid, 1);
        done = 1; taken = 1; tgt = 32'h0000_0102;
        step(); done = 0; taken = 0;
        chk("mis_trap", o_trap, 1);
        chk("mis_cause", o_cause, 4'd0);
        chk("mis_tpc", o_tpc, 32'h102);
        chk("mis_ret", o_instret, 64'd1);
        chk("mis_req", o_req, 0);
        step();
        chk("mis_trap_end", o_trap, 0);
        chk("mis_vec", o_addr, 32'h200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
